mux4_sel_sched: RTL and testbench

Round-robin select scheduler that sits directly upstream of the 4:1 data mux and drives its 2-bit `sel`. It arbitrates four requesting channels, holds the selection stable for the whole grant, and inserts one idle turnaround cycle between grants so the downstream mux never sees `sel` change while a grant is active. Optionally it caps each grant at a fixed dwell time.

---
 rtl/mux4_sel_sched_pkg.sv | 13 +
 rtl/rr_pick4.sv | 27 ++
 rtl/mux4_sel_sched.sv | 100 ++++++++++
 tb/tb_mux4_sel_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_sel_sched_pkg.sv
// rtl/mux4_sel_sched_pkg.sv - shared widths and state type for the mux select scheduler.
package mux4_sel_sched_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } sched_st_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin pick of the first request after the last granted channel.
module rr_pick4
   import mux4_sel_sched_pkg::*;
(
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] lst,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Scan from farthest to nearest so the nearest set bit after lst wins.
   always_comb begin
      pick = lst;
      any  = 1'b0;
      idx  = lst;
      for (int k = NCH; k >= 1; k--) begin
         idx = lst + SEL_W'(k);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_sel_sched.sv
// rtl/mux4_sel_sched.sv - round-robin 4:1 mux select scheduler with idle turnaround.
// Optional dwell-time cap enabled by defining MUX4_SEL_SCHED_TMO_EN.
module mux4_sel_sched
   import mux4_sel_sched_pkg::*;
#(
   parameter int DWELL = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   req,
   input  logic             rel,
   output logic [SEL_W-1:0] sel,
   output logic             sel_vld,
   output logic [NCH-1:0]   gnt,
   output logic             tmo
);

   if (DWELL < 1 || DWELL > 255) begin : g_dwell_range
      $error("DWELL must be in 1..255");
   end

   sched_st_t        st, st_nxt;
   logic [SEL_W-1:0] sel_q, lst_q;
   logic [SEL_W-1:0] pick;
   logic             any;
   logic             end_rel, end_to, tmo_q;

   rr_pick4 u_pick (
      .req  (req),
      .lst  (lst_q),
      .pick (pick),
      .any  (any)
   );

   // A dropped request on the granted channel counts as a release.
   assign end_rel = rel | ~req[sel_q];

`ifdef MUX4_SEL_SCHED_TMO_EN
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;

   assign end_to = (cnt == DWELL_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (st == IDLE) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Timeout is reported only when it is the sole reason the grant ended.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= (st == GRANT) & end_to & ~end_rel;
      end
   end
`else
   assign end_to = 1'b0;
   assign tmo_q  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st    <= IDLE;
         sel_q <= '0;
         lst_q <= SEL_W'(NCH - 1);
      end else begin
         st <= st_nxt;
         if (st == IDLE && any) begin
            sel_q <= pick;
            lst_q <= pick;
         end
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (any) st_nxt = GRANT;
         GRANT:   if (end_rel || end_to) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel     = sel_q;
      sel_vld = (st == GRANT);
      gnt     = '0;
      if (st == GRANT) gnt = NCH'(1) << sel_q;
      tmo     = tmo_q;
   end

endmodule

// File: tb/tb_mux4_sel_sched.sv
// tb/tb_mux4_sel_sched.sv - randomized and directed bench against a grant-owner model.
module tb_mux4_sel_sched;

   localparam int DWELL = 4;
`ifdef MUX4_SEL_SCHED_TMO_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0;
   logic       rel = 1'b0;
   logic [1:0] sel;
   logic       sel_vld;
   logic [3:0] gnt;
   logic       tmo;

   int checks = 0;
   int errors = 0;

   // Model: which channel owns the mux (-1 = none), how long it has owned it.
   int m_own = -1;
   int m_age = 0;
   int m_lst = 3;
   int m_sel = 0;
   bit m_tmo = 1'b0;

   int gq[$];
   bit prev_vld = 1'b0;
   int idle_run = 0;
   int min_gap  = 99;

   mux4_sel_sched #(.DWELL(DWELL)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .rel     (rel),
      .sel     (sel),
      .sel_vld (sel_vld),
      .gnt     (gnt),
      .tmo     (tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      bit endr, endt, found;
      int c;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            m_own = -1; m_age = 0; m_lst = 3; m_sel = 0; m_tmo = 1'b0;
         end else if (m_own < 0) begin
            m_tmo = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               c = (m_lst + k) % 4;
               if (!found && req[c]) begin
                  found = 1'b1;
                  m_own = c; m_lst = c; m_sel = c; m_age = 1;
               end
            end
         end else begin
            endr = rel || !req[m_own];
            endt = TMO_ON && (m_age == DWELL);
            if (endr || endt) begin
               m_tmo = endt && !endr;
               m_own = -1;
            end else begin
               m_tmo = 1'b0;
               m_age++;
            end
         end
         chk("sel", 32'(sel), 32'(m_sel));
         chk("sel_vld", 32'(sel_vld), 32'(m_own >= 0));
         chk("gnt", 32'(gnt), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
         chk("tmo", 32'(tmo), 32'(m_tmo));
         if (sel_vld && !prev_vld) begin
            if (gq.size() > 0 && idle_run < min_gap) min_gap = idle_run;
            gq.push_back(int'(sel));
         end
         idle_run = sel_vld ? 0 : idle_run + 1;
         prev_vld = sel_vld;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 4'b0; rel = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gq.delete();
      min_gap = 99;
   endtask

   task automatic run_rel2(input int n);
      int hc = 0;
      repeat (n) begin
         @(negedge clk);
         hc  = sel_vld ? hc + 1 : 0;
         rel = (hc == 2);
      end
      rel = 1'b0;
   endtask

   initial begin
      int vcnt, tcnt;

      // Rotation through all four channels with 2-cycle grants.
      do_reset();
      req = 4'b1111;
      run_rel2(16);
      chk("t1_ngrants", 32'(gq.size() >= 5), 32'd1);
      if (gq.size() >= 5) begin
         chk("t1_g0", gq[0], 0);
         chk("t1_g1", gq[1], 1);
         chk("t1_g2", gq[2], 2);
         chk("t1_g3", gq[3], 3);
         chk("t1_g4", gq[4], 0);
      end
      chk("t1_gap", min_gap, 1);

      // Last pointer at 1, sparse requests 1010.
      do_reset();
      req = 4'b0010;
      @(negedge clk);
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0; req = 4'b0000;
      @(negedge clk);
      gq.delete();
      req = 4'b1010;
      run_rel2(12);
      chk("t2_ngrants", 32'(gq.size() >= 2), 32'd1);
      if (gq.size() >= 2) begin
         chk("t2_g0", gq[0], 3);
         chk("t2_g1", gq[1], 1);
      end

      // Single held request, no release.
      do_reset();
      req = 4'b0001;
      vcnt = 0; tcnt = 0;
      repeat (12) begin
         @(negedge clk);
         vcnt += int'(sel_vld);
         tcnt += int'(tmo);
      end
`ifdef MUX4_SEL_SCHED_TMO_EN
      chk("t3_vld_cycles", vcnt, 10);
      chk("t3_tmo_pulses", tcnt, 2);
      chk("t3_ngrants", gq.size(), 3);
`else
      chk("t3_vld_cycles", vcnt, 12);
      chk("t3_tmo_pulses", tcnt, 0);
      chk("t3_ngrants", gq.size(), 1);
`endif

      // Release and request drop on the same edge.
      do_reset();
      req = 4'b0100;
      repeat (2) @(negedge clk);
      req = 4'b0000; rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      chk("t4_vld", 32'(sel_vld), 0);
      chk("t4_tmo", 32'(tmo), 0);
      chk("t4_sel", 32'(sel), 2);
      chk("t4_gnt", 32'(gnt), 0);
      chk("t4_model_sel", m_sel, 2);
      chk("t4_model_own", m_own, -1);
      repeat (3) @(negedge clk);
      chk("t4_sel_hold", 32'(sel), 2);

      // Asynchronous reset mid-grant, then restart priority.
      do_reset();
      req = 4'b1000;
      repeat (2) @(negedge clk);
      chk("t5_pre_sel", 32'(sel), 3);
      chk("t5_pre_vld", 32'(sel_vld), 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_sel", 32'(sel), 0);
      chk("t5_async_vld", 32'(sel_vld), 0);
      chk("t5_async_gnt", 32'(gnt), 0);
      chk("t5_async_tmo", 32'(tmo), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_regrant_3", 32'(sel), 3);
      chk("t5_regrant_vld", 32'(sel_vld), 1);
      rst = 1'b1;
      @(negedge clk);
      req = 4'b1001;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_regrant_0", 32'(sel), 0);
      chk("t5_regrant_gnt", 32'(gnt), 1);

      // Randomized traffic with occasional reset.
      do_reset();
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 15) req = 4'($urandom);
         rel = ($urandom_range(0, 99) < 25);
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
